// File: rtl/psi_seq_arbiter_pkg.sv
// Shared parameters and types for the sequential PSI intersection front end.
// Combinational definitions only; no latency.
// No flow control here; the consuming modules handle backpressure.
package psi_pkg;

    localparam int B     = 10;                          // bits per party vector
    localparam int N     = 10;                          // number of parties
    localparam int CNT_W = $clog2(N + 1);               // holds 0..N inclusive
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;     // holds a party index

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_e;

endpackage

// File: rtl/psi_seq_arbiter_if.sv
// Requester and result handshake bundle for psi_seq_arbiter.
// Wires only; no latency.
// Backpressure via req_ready per party and o_ready on the result.
interface psi_seq_arbiter_if;
    import psi_pkg::*;

    logic [N-1:0]   req_valid;
    logic [N*B-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           o_valid;
    logic           o_ready;
    logic [B-1:0]   o;

    // Requesters and result consumer
    modport master (
        output req_valid, req_data, o_ready,
        input  req_ready, o_valid, o
    );

    // The accumulating arbiter
    modport slave (
        input  req_valid, req_data, o_ready,
        output req_ready, o_valid, o
    );

endinterface

// File: rtl/psi_seq_arbiter_arb.sv
// Round-robin pick of the first eligible party at or above the pointer, wrapping.
// Purely combinational, zero latency.
// No backpressure of its own; the parent masks the grant when it cannot accept.
module psi_rr_arbiter
    import psi_pkg::*;
(
    input  logic [N-1:0]     eligible_i,
    input  logic [PTR_W-1:0] rr_ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             any_grant_o
);

    // Walk the offsets from farthest to nearest so the nearest eligible index wins
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (eligible_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o  = PTR_W'(idx);
                any_grant_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/psi_seq_arbiter.sv
// Collects one B-bit vector from each of N parties and outputs their bitwise AND.
// One accept per cycle; result valid 1 cycle after the N-th accept.
// Result held until o_ready; requesters stall (req_ready=0) while the result waits or clear is high.
module psi_seq_arbiter
    import psi_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    psi_seq_arbiter_if.slave bus,
    output logic [CNT_W-1:0] contrib_cnt,
    output logic [N-1:0]     contrib_mask
);

    state_e           state_q, state_d;
    logic [B-1:0]     acc_q, acc_d;
    logic [N-1:0]     mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rr_q, rr_d;

    logic [N-1:0]     eligible;
    logic [N-1:0]     grant;
    logic [PTR_W-1:0] grant_idx;
    logic             any_grant;
    logic             accept_en;
    logic             accept;
    logic [B-1:0]     grant_data;

    // Parties that already contributed sit out until the round restarts
    assign eligible = bus.req_valid & ~mask_q;

    psi_rr_arbiter u_arb (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    // Reset and clear both suppress acceptance in the same cycle
    assign accept_en     = (state_q == COLLECT) && !rst && !clear;
    assign bus.req_ready = accept_en ? grant : '0;
    assign accept        = accept_en && any_grant;
    assign grant_data    = bus.req_data[grant_idx*B +: B];

    assign bus.o_valid   = (state_q == DONE);
    assign bus.o         = bus.o_valid ? acc_q : '0;
    assign contrib_cnt   = cnt_q;
    assign contrib_mask  = mask_q;

    // Next-state: clear outranks both accept and the result handshake; pointer survives round restarts
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        if (clear) begin
            state_d = COLLECT;
            acc_d   = '1;
            mask_d  = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        acc_d  = acc_q & grant_data;
                        mask_d = mask_q | grant;
                        cnt_d  = cnt_q + 1'b1;
                        rr_d   = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
                        if (cnt_d == CNT_W'(N)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.o_ready) begin
                        state_d = COLLECT;
                        acc_d   = '1;
                        mask_d  = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // Round state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            acc_q   <= '1;
            mask_q  <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_psi_seq_arbiter.sv
// Directed bench for psi_seq_arbiter with a grant/result scoreboard.
// Stimulus pushes expected grants and results; a negedge monitor pops and compares.
// Backpressure exercised by holding o_ready low while the result waits.
module tb_psi_seq_arbiter;
    import psi_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [CNT_W-1:0] contrib_cnt;
    logic [N-1:0]     contrib_mask;

    psi_seq_arbiter_if bus();

    psi_seq_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .bus          (bus.slave),
        .contrib_cnt  (contrib_cnt),
        .contrib_mask (contrib_mask)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           grant_q[$];
    logic [B-1:0] result_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Monitor: every handshake on either side must match the next expected entry
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (|(bus.req_valid & bus.req_ready)) begin
                int gi;
                gi = -1;
                for (int i = 0; i < N; i++) begin
                    if (bus.req_valid[i] && bus.req_ready[i]) gi = i;
                end
                chk("req_ready_onehot", 64'($countones(bus.req_ready)), 64'd1);
                if (grant_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: actual party %0d required none at %0t", gi, $time);
                end else begin
                    chk("sb_grant_idx", 64'(gi), 64'(grant_q.pop_front()));
                end
            end
            if (bus.o_valid && bus.o_ready && !clear) begin
                if (result_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual o=%0h required none at %0t", bus.o, $time);
                end else begin
                    chk("sb_result", 64'(bus.o), 64'(result_q.pop_front()));
                end
            end
            if (!bus.o_valid) begin
                chk("o_zero_when_invalid", 64'(bus.o), 64'd0);
            end
        end
    end

    // All parties valid for N cycles, then one result cycle and one idle cycle
    task automatic full_round(input logic [N*B-1:0] data, input logic [B-1:0] expv,
                              input int start, input bit drop_in_done);
        bus.req_data  = data;
        bus.req_valid = '1;
        bus.o_ready   = 1'b1;
        clear         = 1'b0;
        for (int k = 0; k < N; k++) begin
            int g;
            g = (start + k) % N;
            grant_q.push_back(g);
            @(negedge clk);
            chk("round_grant", 64'(bus.req_ready), 64'(onehot(g)));
            tick();
        end
        bus.req_valid = '0;
        if (drop_in_done) clear = 1'b1;
        else              result_q.push_back(expv);
        @(negedge clk);
        chk("round_o_valid", 64'(bus.o_valid), 64'd1);
        chk("round_o", 64'(bus.o), 64'(expv));
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("round_after_valid", 64'(bus.o_valid), 64'd0);
        chk("round_after_cnt", 64'(contrib_cnt), 64'd0);
        chk("round_after_mask", 64'(contrib_mask), 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N*B-1:0] d;

        // Reset with every requester valid
        rst           = 1'b1;
        clear         = 1'b0;
        bus.req_valid = '1;
        bus.o_ready   = 1'b1;
        bus.req_data  = '1;
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
            chk("rst_o", 64'(bus.o), 64'd0);
            chk("rst_cnt", 64'(contrib_cnt), 64'd0);
        end
        tick();
        rst = 1'b0;

        // Full round from party 0; 2F5 & 1FF = 0F5
        for (int i = 0; i < N; i++) d[i*B +: B] = 10'h3FF;
        d[3*B +: B] = 10'h2F5;
        d[7*B +: B] = 10'h1FF;
        full_round(d, 10'h0F5, 0, 1'b0);

        // Repeat requester and result backpressure; rr pointer back at 0
        for (int i = 0; i < N; i++) d[i*B +: B] = 10'h3FF;
        d[5*B +: B]   = 10'h3C3;
        bus.req_data  = d;
        bus.o_ready   = 1'b0;
        bus.req_valid = 10'b0000000111;
        for (int c = 0; c < 3; c++) begin
            grant_q.push_back(c);
            @(negedge clk);
            chk("bp_grant", 64'(bus.req_ready), 64'(onehot(c)));
            tick();
        end
        bus.req_valid = 10'b0000000100;
        repeat (3) begin
            @(negedge clk);
            chk("repeat_no_regrant", 64'(bus.req_ready), 64'd0);
            chk("repeat_mask", 64'(contrib_mask), 64'h007);
            tick();
        end
        bus.req_valid = 10'b1111111100;
        for (int c = 3; c < N; c++) begin
            grant_q.push_back(c);
            @(negedge clk);
            chk("bp_grant", 64'(bus.req_ready), 64'(onehot(c)));
            tick();
        end
        repeat (5) begin
            @(negedge clk);
            chk("hold_o_valid", 64'(bus.o_valid), 64'd1);
            chk("hold_o", 64'(bus.o), 64'h3C3);
            chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        result_q.push_back(10'h3C3);
        bus.o_ready   = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        chk("release_o_valid", 64'(bus.o_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("release_after_valid", 64'(bus.o_valid), 64'd0);
        chk("release_after_cnt", 64'(contrib_cnt), 64'd0);
        chk("release_after_mask", 64'(contrib_mask), 64'd0);
        chk("release_after_o", 64'(bus.o), 64'd0);
        tick();

        // Move pointer to 3 with a grant to party 2, then clear that round
        for (int i = 0; i < N; i++) d[i*B +: B] = 10'h3FF;
        d[6*B +: B]   = 10'h000;
        bus.req_data  = d;
        bus.req_valid = onehot(2);
        grant_q.push_back(2);
        @(negedge clk);
        chk("rr_setup_grant", 64'(bus.req_ready), 64'(onehot(2)));
        tick();
        bus.req_valid = '0;
        clear         = 1'b1;
        @(negedge clk);
        chk("clear_req_ready", 64'(bus.req_ready), 64'd0);
        tick();
        clear = 1'b0;

        // Parties 2 and 5 together with pointer at 3: 5 first, then 2
        bus.req_valid = onehot(2) | onehot(5);
        grant_q.push_back(5);
        @(negedge clk);
        chk("clear_cnt", 64'(contrib_cnt), 64'd0);
        chk("rr_first", 64'(bus.req_ready), 64'(onehot(5)));
        tick();
        grant_q.push_back(2);
        @(negedge clk);
        chk("rr_second", 64'(bus.req_ready), 64'(onehot(2)));
        tick();
        // Pointer now 3: between parties 1 and 4, party 4 wins
        bus.req_valid = onehot(1) | onehot(4);
        grant_q.push_back(4);
        @(negedge clk);
        chk("rr_ptr_3", 64'(bus.req_ready), 64'(onehot(4)));
        tick();
        // Fourth accept carries zero data
        bus.req_valid = onehot(6);
        grant_q.push_back(6);
        @(negedge clk);
        chk("zero_grant", 64'(bus.req_ready), 64'(onehot(6)));
        tick();
        // Clear with party 7 pending: no accept
        bus.req_valid = onehot(7);
        clear         = 1'b1;
        @(negedge clk);
        chk("pre_clear_cnt", 64'(contrib_cnt), 64'd4);
        chk("clear_blocks_accept", 64'(bus.req_ready), 64'd0);
        tick();
        clear         = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        chk("post_clear_cnt", 64'(contrib_cnt), 64'd0);
        chk("post_clear_mask", 64'(contrib_mask), 64'd0);
        tick();

        // Fresh all-ones round from pointer 7; the cleared zero must not leak
        for (int i = 0; i < N; i++) d[i*B +: B] = 10'h3FF;
        full_round(d, 10'h3FF, 7, 1'b0);

        // Clear together with o_ready in DONE drops the result
        full_round(d, 10'h3FF, 7, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("dropped_no_output", 64'(bus.o_valid), 64'd0);
            tick();
        end

        // Next complete round delivers normally: 155 & 0FF = 055
        d[0*B +: B] = 10'h155;
        d[9*B +: B] = 10'h0FF;
        full_round(d, 10'h055, 7, 1'b0);

        chk("grant_q_drained", 64'(grant_q.size()), 64'd0);
        chk("result_q_drained", 64'(result_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psi_seq_arbiter.md
Name: psi_seq_arbiter

Overview:
Sequential front end for the N-party bitwise PSI intersection datapath, where each output bit is the AND of that bit across all N party vectors. Instead of taking all N*B bits in one wide combinational input, the block accepts each party's B-bit vector through its own valid/ready requester port. A round-robin arbiter admits at most one vector per cycle, and that vector is ANDed into an accumulator. Once every party has contributed exactly once, the block presents the B-bit intersection through a valid/ready result handshake.

Parameters:
B, 10, bits per party vector (set-membership bitmap width)
N, 10, number of parties / requester ports

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  N  per-party vector valid
req_data  in  N*B  party i vector at [i*B +: B]
req_ready  out  N  per-party accept; at most one bit set per cycle
clear  in  1  synchronous abort of the current round
o_valid  out  1  intersection result valid
o_ready  in  1  consumer accepts result
o  out  B  intersection result
contrib_cnt  out  clog2(N+1)  number of parties accepted this round
contrib_mask  out  N  bit i set when party i has contributed this round

Behaviour:
- Single clock domain. Reset is synchronous and active-high (rst), applied on the rising edge of clk.
- Reset values:
  - state = COLLECT, acc = all ones, contrib_mask = 0, contrib_cnt = 0, rr_ptr = 0.
  - o_valid = 0, o = 0.
  - req_ready = 0 while rst = 1.
- States: COLLECT, DONE.
- COLLECT:
  - eligible = req_valid & ~contrib_mask.
  - Grant goes to the first eligible index found searching upward from rr_ptr, wrapping past N-1 to 0.
  - req_ready is one-hot on the granted index, or 0 if nothing is eligible. req_ready depends combinationally on req_valid, the state, the mask and rr_ptr.
- Accept on party g (req_valid[g] & req_ready[g]), effective next cycle:
  - acc <= acc & req_data[g].
  - contrib_mask[g] <= 1, contrib_cnt += 1.
  - rr_ptr <= (g+1) mod N.
- The accept that brings contrib_cnt to N moves the state to DONE. o_valid = 1 on the following cycle, so latency is 1 cycle after the last accept.
- DONE:
  - o_valid = 1, o = acc. All req_ready = 0.
  - o and o_valid are held stable until o_ready = 1.
  - On o_valid & o_ready: next cycle state = COLLECT, acc = all ones, mask = 0, cnt = 0, o_valid = 0. rr_ptr is kept.
- o = 0 whenever o_valid = 0.
- A party already in contrib_mask is never granted again in the same round, even if it holds req_valid high. It is first eligible in the cycle after the round resets.
- clear = 1 (any state):
  - Next cycle acc = all ones, mask = 0, cnt = 0, state = COLLECT, o_valid = 0. rr_ptr is kept.
  - req_ready = 0 in the clear cycle, so no accept occurs.
  - clear has priority over both an accept and the output handshake.
- A zero acc does not end the round early; the round still waits for all N parties.
- contrib_cnt never exceeds N. Round-robin wrap: a grant to N-1 sets rr_ptr = 0.
- rst asserted mid-round discards all partial state with no output.

Decomposition:
- Package psi_pkg:
  - B and N defaults.
  - CNT_W = clog2(N+1).
  - State enum {COLLECT, DONE}.
- Sub-module psi_rr_arbiter:
  - Inputs: N-bit eligible vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational. The pointer register lives in the parent.

Test Plan:
- Reset check: hold rst 3 cycles with all req_valid = 1. Expect req_ready = 0, o_valid = 0, o = 0, contrib_cnt = 0. After release, the first grant is to party 0.
- Full round with all parties valid:
  - Stimulus: all req_valid = 1 from cycle 0. Party data = 10'h3FF, except party 3 = 10'h2F5 and party 7 = 10'h1FF.
  - Expect grants to parties 0..9 on cycles 0..9, then o_valid = 1 on cycle 10 with o = 10'h0F5.
- Repeat and backpressure:
  - Party 2 keeps req_valid = 1 after its accept. Expect no second grant to party 2 and contrib_mask[2] stays 1.
  - After the round, hold o_ready = 0 for 5 cycles. Expect o and o_valid stable and req_ready = 0.
  - Then o_ready = 1. Expect o_valid = 0, cnt = 0 and mask = 0 the next cycle.
- Round-robin order: with rr_ptr = 3, raise only parties 2 and 5 together. Expect grant to 5 first, then 2 the next cycle, then rr_ptr = 3.
- clear mid-round:
  - After 4 accepts (one carried data 10'h000), assert clear together with a pending req_valid. Expect no accept in that cycle and cnt = 0 the next cycle.
  - A fresh round of all-ones vectors then yields o = 10'h3FF.
- clear in DONE with o_ready = 1 in the same cycle: the result is dropped, o_valid = 0 the next cycle, and no further output occurs until a new full round completes.
